sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one single-port SRAM macro (7-bit address, 32-bit data, active-low chip select and write enable) between two requesters.
- Arbitration is round-robin. Requests use a valid/ready handshake; read responses return on a fixed-latency valid strobe.
- After reset, the block optionally zero-fills the whole macro before accepting traffic.
- Sits between the core-side masters and the SRAM wrapper; the wrapper supplies the inverted clock to the macro.

Parameters:
ADDR_W, 7, SRAM address width
DATA_W, 32, SRAM data width
DEPTH, 128, words in the macro; must equal 2^ADDR_W
INIT_ZERO, 1, 1 = zero-fill all DEPTH words after reset; 0 = go straight to RUN

Ports:
clock  in  1  single clock for all state; rising edge
reset  in  1  asynchronous, active-low reset
io_req0_valid  in  1  requester 0 request valid
io_req0_ready  out  1  requester 0 request accepted this cycle (when valid)
io_req0_write  in  1  1 = write, 0 = read
io_req0_addr  in  ADDR_W  word address
io_req0_wdata  in  DATA_W  write data
io_rsp0_valid  out  1  requester 0 read data valid, one-cycle strobe
io_rsp0_rdata  out  DATA_W  requester 0 read data
io_req1_*, io_rsp1_*  same set for requester 1
io_sram_csb0  out  1  macro chip select, active-low
io_sram_web0  out  1  macro write enable, active-low
io_sram_addr0  out  ADDR_W  macro address
io_sram_din0  out  DATA_W  macro write data
io_sram_dout0  in  DATA_W  macro read data
io_init_done  out  1  high once INIT has completed; stays high until reset

Behaviour:
- Reset values (asynchronous, while reset=0):
  - ready=0, rsp_valid=0, rsp_rdata=0.
  - csb0=1, web0=1, addr0=0, din0=0.
  - init_done=0, priority pointer = requester 0, state = INIT (or RUN if INIT_ZERO=0).
- FSM states: INIT, RUN.
- INIT:
  - Counter k runs 0..DEPTH-1, one per cycle, with registered csb0=0, web0=0, addr0=k, din0=0.
  - Both ready outputs are held at 0.
  - After the write with k=DEPTH-1 is driven, the next edge enters RUN and sets init_done=1.
  - Total DEPTH cycles.
- RUN, ready:
  - ready0 = (!valid1 | prio==0); ready1 = (!valid0 | prio==1).
  - Ready never depends on the requester's own valid.
  - Transfer happens when valid & ready; at most one transfer per cycle.
- Priority:
  - On a cycle where both are valid, the grant goes to prio, and prio flips to the loser.
  - A single valid requester is granted without changing prio.
- Issue (transfer at edge E):
  - SRAM outputs are registered at E: csb0=0, web0=!write, addr0=addr, din0=wdata.
  - With no transfer: csb0=1, web0=1, addr0/din0 hold.
- Read return:
  - The macro samples on the falling edge after E.
  - At edge E+1 the block registers io_sram_dout0 into the owner's rsp_rdata and drives that owner's rsp_valid=1 for exactly one cycle.
  - rsp_rdata holds until that requester's next read response.
  - Writes produce no response.
- Throughput and ordering:
  - Sustains one access per cycle, back-to-back.
  - Ordering is strict issue order; a read following a write to the same address returns the new data.
- Simultaneous read response and new issue are allowed. The response owner is tracked in a pipeline register, independent of the current grant.
- Reset mid-operation:
  - All state returns immediately to reset values; an in-flight read response is dropped.
  - INIT re-runs after reset deasserts.

Optional Feature:
- Macro: SRAM_ARB_STATS_EN.
- Defined: adds outputs io_stat_grant0, io_stat_grant1 and io_stat_conflict, each 16 bits, saturating at 0xFFFF and cleared by reset.
  - io_stat_grant0/1 count transfers per requester in RUN.
  - io_stat_conflict counts RUN cycles where both valid inputs are 1.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- INIT_ZERO=1, release reset:
  - ready0/1 are 0 for 128 cycles; csb0=0, web0=0, addr0 steps 0..127, din0=0.
  - init_done rises on the next edge.
  - A req0 read of addr 5 then returns rsp0_rdata=0.
- req0 writes addr 0x10, data 0xDEADBEEF at edge E; req0 reads 0x10 at E+1:
  - rsp0_valid=1 at E+2 only, with rsp0_rdata=0xDEADBEEF; rsp1_valid stays 0.
- Both requesters valid for 6 cycles, starting with prio=0:
  - Grants alternate 0,1,0,1,0,1; each ready is high every other cycle.
  - Read responses return on the matching requester one cycle after each issue.
- req1 alone valid for 4 cycles (prio=0):
  - Four consecutive grants to req1; prio stays 0.
  - A following both-valid cycle grants req0.
- reset=0 asserted one cycle after a read issue:
  - All outputs go to reset values immediately; no rsp_valid appears.
  - After release, INIT restarts from addr 0.
- With SRAM_ARB_STATS_EN and 10 both-valid cycles:
  - io_stat_conflict=10, io_stat_grant0=5, io_stat_grant1=5.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM macro between two valid/ready requesters.
// Optional statistics counters are enabled by defining SRAM_ARB_STATS_EN.
module sram_port_arbiter #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 128,
    parameter int INIT_ZERO = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_req0_valid,
    output logic              io_req0_ready,
    input  logic              io_req0_write,
    input  logic [ADDR_W-1:0] io_req0_addr,
    input  logic [DATA_W-1:0] io_req0_wdata,
    output logic              io_rsp0_valid,
    output logic [DATA_W-1:0] io_rsp0_rdata,
    input  logic              io_req1_valid,
    output logic              io_req1_ready,
    input  logic              io_req1_write,
    input  logic [ADDR_W-1:0] io_req1_addr,
    input  logic [DATA_W-1:0] io_req1_wdata,
    output logic              io_rsp1_valid,
    output logic [DATA_W-1:0] io_rsp1_rdata,
    output logic              io_sram_csb0,
    output logic              io_sram_web0,
    output logic [ADDR_W-1:0] io_sram_addr0,
    output logic [DATA_W-1:0] io_sram_din0,
    input  logic [DATA_W-1:0] io_sram_dout0,
    output logic              io_init_done
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [15:0]       io_stat_grant0,
    output logic [15:0]       io_stat_grant1,
    output logic [15:0]       io_stat_conflict
`endif
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam int KW = ADDR_W + 1;
    localparam state_t RST_STATE = (INIT_ZERO != 0) ? S_INIT : S_RUN;
    localparam logic [KW-1:0] K_END = KW'(DEPTH);
    localparam logic [KW-1:0] K_ONE = KW'(1);

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic              prio_q, prio_d;
    logic              csb_q, csb_d;
    logic              web_q, web_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_own_q, rd_own_d;
    logic              rsp0_vld_q, rsp0_vld_d;
    logic              rsp1_vld_q, rsp1_vld_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              init_done_q, init_done_d;

    logic run, rdy0, rdy1, go0, go1, both;

    // Ready is gated by reset so it reads 0 while reset is held, even when RUN is the reset state.
    assign run  = (state_q == S_RUN);
    assign both = io_req0_valid & io_req1_valid;
    assign rdy0 = run & reset & (~io_req1_valid | ~prio_q);
    assign rdy1 = run & reset & (~io_req0_valid |  prio_q);
    assign go0  = io_req0_valid & rdy0;
    assign go1  = io_req1_valid & rdy1;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        prio_d      = prio_q;
        csb_d       = 1'b1;
        web_d       = 1'b1;
        addr_d      = addr_q;
        din_d       = din_q;
        rd_vld_d    = 1'b0;
        rd_own_d    = rd_own_q;
        init_done_d = init_done_q;
        // The response owner comes from the issue pipeline, not from this cycle's grant.
        rsp0_vld_d  = rd_vld_q & ~rd_own_q;
        rsp1_vld_d  = rd_vld_q &  rd_own_q;
        rdata0_d    = rsp0_vld_d ? io_sram_dout0 : rdata0_q;
        rdata1_d    = rsp1_vld_d ? io_sram_dout0 : rdata1_q;
        case (state_q)
            S_INIT: begin
                if (k_q == K_END) begin
                    state_d     = S_RUN;
                    init_done_d = 1'b1;
                end else begin
                    csb_d  = 1'b0;
                    web_d  = 1'b0;
                    addr_d = k_q[ADDR_W-1:0];
                    din_d  = '0;
                    k_d    = k_q + K_ONE;
                end
            end
            default: begin
                init_done_d = 1'b1;
                if (both) begin
                    prio_d = ~prio_q;
                end
                if (go0 | go1) begin
                    csb_d    = 1'b0;
                    web_d    = go1 ? ~io_req1_write : ~io_req0_write;
                    addr_d   = go1 ? io_req1_addr : io_req0_addr;
                    din_d    = go1 ? io_req1_wdata : io_req0_wdata;
                    rd_vld_d = go1 ? ~io_req1_write : ~io_req0_write;
                    rd_own_d = go1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= RST_STATE;
            k_q         <= '0;
            prio_q      <= 1'b0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            addr_q      <= '0;
            din_q       <= '0;
            rd_vld_q    <= 1'b0;
            rd_own_q    <= 1'b0;
            rsp0_vld_q  <= 1'b0;
            rsp1_vld_q  <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            prio_q      <= prio_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rd_vld_q    <= rd_vld_d;
            rd_own_q    <= rd_own_d;
            rsp0_vld_q  <= rsp0_vld_d;
            rsp1_vld_q  <= rsp1_vld_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            init_done_q <= init_done_d;
        end
    end

    assign io_req0_ready = rdy0;
    assign io_req1_ready = rdy1;
    assign io_rsp0_valid = rsp0_vld_q;
    assign io_rsp1_valid = rsp1_vld_q;
    assign io_rsp0_rdata = rdata0_q;
    assign io_rsp1_rdata = rdata1_q;
    assign io_sram_csb0  = csb_q;
    assign io_sram_web0  = web_q;
    assign io_sram_addr0 = addr_q;
    assign io_sram_din0  = din_q;
    assign io_init_done  = init_done_q;

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] grant0_q, grant0_d;
    logic [15:0] grant1_q, grant1_d;
    logic [15:0] conflict_q, conflict_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    always_comb begin
        grant0_d   = sat_inc(grant0_q, go0);
        grant1_d   = sat_inc(grant1_q, go1);
        conflict_d = sat_inc(conflict_q, run & both);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant0_q   <= '0;
            grant1_q   <= '0;
            conflict_q <= '0;
        end else begin
            grant0_q   <= grant0_d;
            grant1_q   <= grant1_d;
            conflict_q <= conflict_d;
        end
    end

    assign io_stat_grant0   = grant0_q;
    assign io_stat_grant1   = grant1_q;
    assign io_stat_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: vector table for RUN traffic plus INIT and mid-operation reset sequences.
module tb_sram_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_write;
    logic [6:0]  req0_addr;
    logic [31:0] req0_wdata;
    logic        rsp0_valid;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_write;
    logic [6:0]  req1_addr;
    logic [31:0] req1_wdata;
    logic        rsp1_valid;
    logic [31:0] rsp1_rdata;
    logic        sram_csb0, sram_web0;
    logic [6:0]  sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0;
    logic        init_done;
`ifdef SRAM_ARB_STATS_EN
    logic [15:0] stat_grant0, stat_grant1, stat_conflict;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sram_port_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .io_req0_valid (req0_valid),
        .io_req0_ready (req0_ready),
        .io_req0_write (req0_write),
        .io_req0_addr  (req0_addr),
        .io_req0_wdata (req0_wdata),
        .io_rsp0_valid (rsp0_valid),
        .io_rsp0_rdata (rsp0_rdata),
        .io_req1_valid (req1_valid),
        .io_req1_ready (req1_ready),
        .io_req1_write (req1_write),
        .io_req1_addr  (req1_addr),
        .io_req1_wdata (req1_wdata),
        .io_rsp1_valid (rsp1_valid),
        .io_rsp1_rdata (rsp1_rdata),
        .io_sram_csb0  (sram_csb0),
        .io_sram_web0  (sram_web0),
        .io_sram_addr0 (sram_addr0),
        .io_sram_din0  (sram_din0),
        .io_sram_dout0 (sram_dout0),
        .io_init_done  (init_done)
`ifdef SRAM_ARB_STATS_EN
        ,
        .io_stat_grant0   (stat_grant0),
        .io_stat_grant1   (stat_grant1),
        .io_stat_conflict (stat_conflict)
`endif
    );

    // Macro model: the wrapper clocks the macro on the inverted clock.
    logic [31:0] mem [128];
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'hA5A5_0000 | i;
        sram_dout0 = 32'h0;
    end
    always @(negedge clock) begin
        if (!sram_csb0) begin
            if (!sram_web0) mem[sram_addr0] = sram_din0;
            else            sram_dout0 = mem[sram_addr0];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 7'h0; req0_wdata = 32'h0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 7'h0; req1_wdata = 32'h0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        v0, w0; logic [6:0] a0; logic [31:0] d0;
        logic        v1, w1; logic [6:0] a1; logic [31:0] d1;
        logic        rdy0, rdy1;
        logic        csb, web; logic [6:0] addr; logic [31:0] din;
        logic        rv0, rv1; logic [31:0] rd0, rd1;
    } vec_t;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;
    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] A  = 32'h11112222;
    localparam logic [31:0] B  = 32'h33334444;
    localparam logic [31:0] Z  = 32'h0;

    vec_t vecs [20];

    initial begin
        // Inputs, ready before the edge, then SRAM pins and responses after the edge.
        vecs[0]  = '{T,F,7'h05,Z,  F,F,7'h00,Z,  T,F, F,T,7'h05,Z,  F,F, Z,Z};
        vecs[1]  = '{T,T,7'h10,DB, F,F,7'h00,Z,  T,F, F,F,7'h10,DB, T,F, Z,Z};
        vecs[2]  = '{T,F,7'h10,Z,  F,F,7'h00,Z,  T,F, F,T,7'h10,Z,  F,F, Z,Z};
        vecs[3]  = '{F,F,7'h00,Z,  F,F,7'h00,Z,  T,T, T,T,7'h10,Z,  T,F, DB,Z};
        vecs[4]  = '{F,F,7'h00,Z,  F,F,7'h00,Z,  T,T, T,T,7'h10,Z,  F,F, DB,Z};
        vecs[5]  = '{F,F,7'h00,Z,  T,T,7'h20,A,  T,T, F,F,7'h20,A,  F,F, DB,Z};
        vecs[6]  = '{T,T,7'h21,B,  F,F,7'h00,Z,  T,F, F,F,7'h21,B,  F,F, DB,Z};
        vecs[7]  = '{T,F,7'h20,Z,  T,F,7'h21,Z,  T,F, F,T,7'h20,Z,  F,F, DB,Z};
        vecs[8]  = '{T,F,7'h20,Z,  T,F,7'h21,Z,  F,T, F,T,7'h21,Z,  T,F, A,Z};
        vecs[9]  = '{T,F,7'h20,Z,  T,F,7'h21,Z,  T,F, F,T,7'h20,Z,  F,T, A,B};
        vecs[10] = '{T,F,7'h20,Z,  T,F,7'h21,Z,  F,T, F,T,7'h21,Z,  T,F, A,B};
        vecs[11] = '{T,F,7'h20,Z,  T,F,7'h21,Z,  T,F, F,T,7'h20,Z,  F,T, A,B};
        vecs[12] = '{T,F,7'h20,Z,  T,F,7'h21,Z,  F,T, F,T,7'h21,Z,  T,F, A,B};
        vecs[13] = '{F,F,7'h00,Z,  T,F,7'h10,Z,  T,T, F,T,7'h10,Z,  F,T, A,B};
        vecs[14] = '{F,F,7'h00,Z,  T,F,7'h10,Z,  T,T, F,T,7'h10,Z,  F,T, A,DB};
        vecs[15] = '{F,F,7'h00,Z,  T,F,7'h10,Z,  T,T, F,T,7'h10,Z,  F,T, A,DB};
        vecs[16] = '{F,F,7'h00,Z,  T,F,7'h10,Z,  T,T, F,T,7'h10,Z,  F,T, A,DB};
        vecs[17] = '{T,F,7'h21,Z,  T,F,7'h20,Z,  T,F, F,T,7'h21,Z,  F,T, A,DB};
        vecs[18] = '{F,F,7'h00,Z,  F,F,7'h00,Z,  T,T, T,T,7'h21,Z,  T,F, B,DB};
        vecs[19] = '{F,F,7'h00,Z,  F,F,7'h00,Z,  T,T, T,T,7'h21,Z,  F,F, B,DB};

        reset = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", {30'h0, req0_ready, req1_ready}, 32'h0);
        chk("rst_rsp_valid", {30'h0, rsp0_valid, rsp1_valid}, 32'h0);
        chk("rst_rdata0", rsp0_rdata, Z);
        chk("rst_rdata1", rsp1_rdata, Z);
        chk("rst_sram_ctl", {29'h0, sram_csb0, sram_web0, init_done}, 32'h6);
        chk("rst_sram_addr", {25'h0, sram_addr0}, 32'h0);
        chk("rst_sram_din", sram_din0, Z);

        reset = 1'b1;
        for (int k = 0; k < 128; k++) begin
            tick();
            chk("init_ctl", {27'h0, sram_csb0, sram_web0, req0_ready, req1_ready, init_done}, 32'h0);
            chk("init_addr", {25'h0, sram_addr0}, k);
            chk("init_din", sram_din0, Z);
        end
        tick();
        chk("init_done", {31'h0, init_done}, 32'h1);
        chk("run_idle_csb", {31'h0, sram_csb0}, 32'h1);
        chk("run_idle_ready", {30'h0, req0_ready, req1_ready}, 32'h3);
        for (int i = 0; i < 128; i++) begin
            if (mem[i] != 32'h0) begin
                chk("zero_fill", mem[i], Z);
                break;
            end
        end

        for (int i = 0; i < 20; i++) begin
            req0_valid = vecs[i].v0; req0_write = vecs[i].w0;
            req0_addr  = vecs[i].a0; req0_wdata = vecs[i].d0;
            req1_valid = vecs[i].v1; req1_write = vecs[i].w1;
            req1_addr  = vecs[i].a1; req1_wdata = vecs[i].d1;
            #1;
            chk($sformatf("v%0d_ready0", i), {31'h0, req0_ready}, {31'h0, vecs[i].rdy0});
            chk($sformatf("v%0d_ready1", i), {31'h0, req1_ready}, {31'h0, vecs[i].rdy1});
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_csb", i), {31'h0, sram_csb0}, {31'h0, vecs[i].csb});
            chk($sformatf("v%0d_web", i), {31'h0, sram_web0}, {31'h0, vecs[i].web});
            chk($sformatf("v%0d_addr", i), {25'h0, sram_addr0}, {25'h0, vecs[i].addr});
            chk($sformatf("v%0d_din", i), sram_din0, vecs[i].din);
            chk($sformatf("v%0d_rsp0_valid", i), {31'h0, rsp0_valid}, {31'h0, vecs[i].rv0});
            chk($sformatf("v%0d_rsp1_valid", i), {31'h0, rsp1_valid}, {31'h0, vecs[i].rv1});
            chk($sformatf("v%0d_rdata0", i), rsp0_rdata, vecs[i].rd0);
            chk($sformatf("v%0d_rdata1", i), rsp1_rdata, vecs[i].rd1);
        end

        // Read issued, then reset lands before its response edge.
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 7'h10;
        tick();
        chk("pre_rst_issue_csb", {31'h0, sram_csb0}, 32'h0);
        clear_inputs();
        reset = 1'b0;
        #1;
        chk("mid_rst_ctl", {27'h0, sram_csb0, sram_web0, req0_ready, rsp0_valid, init_done}, 32'h18);
        chk("mid_rst_addr", {25'h0, sram_addr0}, 32'h0);
        chk("mid_rst_rdata0", rsp0_rdata, Z);
        chk("mid_rst_rdata1", rsp1_rdata, Z);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_hold_rsp", {30'h0, rsp0_valid, rsp1_valid}, 32'h0);
            chk("rst_hold_csb", {31'h0, sram_csb0}, 32'h1);
        end
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("reinit_addr", {25'h0, sram_addr0}, k);
            chk("reinit_ctl", {29'h0, sram_csb0, sram_web0, init_done}, 32'h0);
        end
        for (int i = 0; i < 300 && !init_done; i++) tick();
        chk("reinit_done", {31'h0, init_done}, 32'h1);

`ifdef SRAM_ARB_STATS_EN
        chk("stat_clear", {stat_grant0, stat_conflict}, 32'h0);
        req0_valid = 1'b1; req0_addr = 7'h01;
        req1_valid = 1'b1; req1_addr = 7'h02;
        repeat (10) tick();
        clear_inputs();
        tick();
        chk("stat_conflict", {16'h0, stat_conflict}, 32'd10);
        chk("stat_grant0", {16'h0, stat_grant0}, 32'd5);
        chk("stat_grant1", {16'h0, stat_grant1}, 32'd5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
